// File: rtl/moore_stream_sched_if.sv
// Bundle between the scheduler, its two word producers and the Moore FSM.
// Ports: req/data0/data1/gnt, busy, fsm_clr/fsm_in/fsm_out, done/done_id/hit_cnt.
interface moore_stream_sched_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) ();
  logic [1:0]    req;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    gnt;
  logic          busy;
  logic          fsm_clr;
  logic          fsm_in;
  logic [1:0]    fsm_out;
  logic          done;
  logic          done_id;
  logic [CW-1:0] hit_cnt;

  modport master (
    output req, data0, data1, fsm_out,
    input  gnt, busy, fsm_clr, fsm_in,
    input  done, done_id, hit_cnt
  );

  modport slave (
    input  req, data0, data1, fsm_out,
    output gnt, busy, fsm_clr, fsm_in,
    output done, done_id, hit_cnt
  );
endinterface

// File: rtl/moore_stream_sched.sv
// Round-robin share of one serial Moore FSM: grant, clear, stream word MSB-first,
// count MATCH outputs. Ports: clk, rst (sync, high), bus (slave side of the if).
module moore_stream_sched #(
  parameter int          W     = 8,
  parameter logic [1:0]  MATCH = 2'b01,
  parameter int          CW    = $clog2(W+1)
) (
  input  logic clk,
  input  logic rst,
  moore_stream_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] KLAST = CW'(W-1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          last_q;
  logic [W-1:0]  shreg_q;
  logic [CW-1:0] k_q;
  logic [CW-1:0] acc_q;
  logic [CW-1:0] hit_q;
  logic          id_q;
  logic          hit;

  logic [1:0]    gnt_c;
  logic          busy_c;
  logic          clr_c;
  logic          fin_c;
  logic          done_c;

  assign hit = (bus.fsm_out == MATCH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gnt_c   = 2'b00;
    busy_c  = 1'b0;
    clr_c   = rst;
    fin_c   = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d = S_LOAD;
          // on contention the requester not served last wins
          if (bus.req == 2'b11) win_d = ~last_q;
          else                  win_d = bus.req[1];
        end
      end
      S_LOAD: begin
        gnt_c   = win_q ? 2'b10 : 2'b01;
        busy_c  = 1'b1;
        clr_c   = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy_c = 1'b1;
        fin_c  = shreg_q[W-1];
        if (k_q == KLAST) state_d = S_TAIL;
      end
      S_TAIL: begin
        busy_c  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // reset wins immediately so a job cut short never grants or reports
    if (rst) begin
      gnt_c  = 2'b00;
      busy_c = 1'b0;
      fin_c  = 1'b0;
      done_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      shreg_q <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      hit_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      win_q <= win_d;
      case (state_q)
        S_LOAD: begin
          shreg_q <= win_q ? bus.data1 : bus.data0;
          acc_q   <= '0;
          k_q     <= '0;
          last_q  <= win_q;
        end
        S_SHIFT: begin
          shreg_q <= {shreg_q[W-2:0], 1'b0};
          k_q     <= k_q + ONE;
          // fsm_out lags fsm_in by one cycle; k=0 still shows cleared state
          if (k_q != '0 && hit) acc_q <= acc_q + ONE;
        end
        S_TAIL: begin
          hit_q <= acc_q + CW'(hit);
          id_q  <= win_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.busy    = busy_c;
  assign bus.fsm_clr = clr_c;
  assign bus.fsm_in  = fin_c;
  assign bus.done    = done_c;
  assign bus.done_id = id_q;
  assign bus.hit_cnt = hit_q;

endmodule

// File: tb/tb_moore_stream_sched.sv
// Directed bench for moore_stream_sched with a one-cycle echo FSM stub,
// so each job's hit count equals the popcount of the streamed word.
module tb_moore_stream_sched;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  moore_stream_sched_if #(.W(W), .CW(CW)) bus ();

  moore_stream_sched #(.W(W), .MATCH(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    bus.fsm_out <= bus.fsm_clr ? 2'b00 : {1'b0, bus.fsm_in};

  task automatic test_reset;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b00) begin
      failures++;
      $display("FAIL rst_gnt got=%b exp=00", bus.gnt);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_done got=%b%b exp=00", bus.busy, bus.done);
    end
    checks++;
    if (bus.hit_cnt !== 4'd0 || bus.done_id !== 1'b0) begin
      failures++;
      $display("FAIL rst_result got=%0d/%b exp=0/0", bus.hit_cnt, bus.done_id);
    end
    checks++;
    if (bus.fsm_clr !== 1'b1 || bus.fsm_in !== 1'b0) begin
      failures++;
      $display("FAIL rst_fsm got=%b%b exp=10", bus.fsm_clr, bus.fsm_in);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fsm_clr !== 1'b0) begin
      failures++;
      $display("FAIL idle_clr got=%b exp=0", bus.fsm_clr);
    end
  endtask

  task automatic test_single;
    logic [7:0] w;
    w = 8'hA5;
    bus.req = 2'b01;
    bus.data0 = w;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01 || bus.busy !== 1'b1 || bus.fsm_clr !== 1'b1) begin
      failures++;
      $display("FAIL load got=%b/%b/%b exp=01/1/1",
               bus.gnt, bus.busy, bus.fsm_clr);
    end
    bus.req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fsm_in !== w[7-i]) begin
        failures++;
        $display("FAIL bit%0d got=%b exp=%b", i, bus.fsm_in, w[7-i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.fsm_in !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL tail got=%b%b exp=00", bus.fsm_in, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd4 || bus.done_id !== 1'b0) begin
      failures++;
      $display("FAIL single_done got=%b/%0d/%b exp=1/4/0",
               bus.done, bus.hit_cnt, bus.done_id);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hit_cnt !== 4'd4) begin
      failures++;
      $display("FAIL single_hold got=%b/%b/%0d exp=0/0/4",
               bus.done, bus.busy, bus.hit_cnt);
    end
  endtask

  task automatic test_rr_pair;
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b11;
    bus.data0 = 8'hFF;
    bus.data1 = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01) begin
      failures++;
      $display("FAIL rr_first got=%b exp=01", bus.gnt);
    end
    bus.req = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL rr_latency got=%0d exp=10", n);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd8 || bus.done_id !== 1'b0) begin
      failures++;
      $display("FAIL rr_job0 got=%b/%0d/%b exp=1/8/0",
               bus.done, bus.hit_cnt, bus.done_id);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 20);
    checks++;
    if (n !== 2 || bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL rr_second got=%0d/%b exp=2/10", n, bus.gnt);
    end
    bus.req = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd0 || bus.done_id !== 1'b1) begin
      failures++;
      $display("FAIL rr_job1 got=%b/%0d/%b exp=1/0/1",
               bus.done, bus.hit_cnt, bus.done_id);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [1:0] exp;
    bus.req = 2'b11;
    bus.data0 = 8'h0F;
    bus.data1 = 8'h07;
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 30);
      checks++;
      if (bus.gnt !== exp) begin
        failures++;
        $display("FAIL b2b_grant%0d got=%b exp=%b", g, bus.gnt, exp);
      end
    end
    bus.req = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd3 || bus.done_id !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last got=%b/%0d/%b exp=1/3/1",
               bus.done, bus.hit_cnt, bus.done_id);
    end
  endtask

  task automatic test_rst_mid;
    int n;
    bus.req = 2'b11;
    bus.data0 = 8'hFF;
    bus.data1 = 8'h0F;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 20);
    checks++;
    if (bus.gnt !== 2'b01) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=01", bus.gnt);
    end
    bus.req = 2'b10;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b exp=1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gnt !== 2'b00) begin
      failures++;
      $display("FAIL mid_abort got=%b/%b/%b exp=0/0/00",
               bus.busy, bus.done, bus.gnt);
    end
    checks++;
    if (bus.hit_cnt !== 4'd0 || bus.done_id !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear got=%0d/%b exp=0/0", bus.hit_cnt, bus.done_id);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL mid_regrant got=%b exp=10", bus.gnt);
    end
    bus.req = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd4 || bus.done_id !== 1'b1) begin
      failures++;
      $display("FAIL mid_job got=%b/%0d/%b exp=1/4/1",
               bus.done, bus.hit_cnt, bus.done_id);
    end
  endtask

  task automatic test_late_req;
    int n;
    logic stray;
    bus.req = 2'b01;
    bus.data0 = 8'h3C;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 20);
    checks++;
    if (bus.gnt !== 2'b01) begin
      failures++;
      $display("FAIL late_grant0 got=%b exp=01", bus.gnt);
    end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    bus.req = 2'b10;
    bus.data1 = 8'h81;
    stray = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.gnt !== 2'b00) stray = 1'b1;
    end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (stray !== 1'b0) begin
      failures++;
      $display("FAIL late_stray got=%b exp=0", stray);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd4 || bus.done_id !== 1'b0) begin
      failures++;
      $display("FAIL late_job0 got=%b/%0d/%b exp=1/4/0",
               bus.done, bus.hit_cnt, bus.done_id);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL late_idle got=%b/%b exp=00/0", bus.gnt, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL late_grant1 got=%b exp=10", bus.gnt);
    end
    bus.req = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 20);
    checks++;
    if (bus.done !== 1'b1 || bus.hit_cnt !== 4'd2 || bus.done_id !== 1'b1) begin
      failures++;
      $display("FAIL late_job1 got=%b/%0d/%b exp=1/2/1",
               bus.done, bus.hit_cnt, bus.done_id);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_rr_pair();
    test_back_to_back();
    test_rst_mid();
    test_late_req();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
